// File: rtl/seq_pkg.sv
// Shared types for the serial pattern generator and its detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_gen_state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in/serial-out shift register, MSB first; load wins over shift.
// msb_nxt is the MSB after this edge, so the owner can register its output bit.
module seq_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] load_dat,
  input  logic             shift_en,
  output logic             msb_nxt,
  output logic             last
);

  localparam int IDX_W = $clog2(PAT_W);

  logic [PAT_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load) begin
      sr_d  = load_dat;
      idx_d = '0;
    end else if (shift_en) begin
      sr_d  = {sr_q[PAT_W-2:0], 1'b0};
      idx_d = (idx_q == IDX_W'(PAT_W-1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign msb_nxt = sr_d[PAT_W-1];
  assign last    = (idx_q == IDX_W'(PAT_W-1));

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first repeat_cnt times over valid/ready.
// Define SEQ_GEN_GAP_EN to insert GAP_CYCLES idle cycles between repetitions.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W      = 4,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  seq_gen_state_t   state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ld;
  logic [PAT_W-1:0] ld_dat;
  logic             shift_en;
  logic             msb_nxt;
  logic             last_bit;
  logic             xfer;

`ifdef SEQ_GEN_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  assign xfer = dout_valid_q & dout_ready;

  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    reps_d       = reps_q;
    ld           = 1'b0;
    ld_dat       = pat_q;
    shift_en     = 1'b0;
    dout_valid_d = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    gap_d        = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SHIFT;
          pat_d        = pattern;
          reps_d       = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
          ld           = 1'b1;
          ld_dat       = pattern;
          dout_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        dout_valid_d = 1'b1;
        if (xfer) begin
          if (last_bit) begin
            reps_d = reps_q - CNT_W'(1);
            if (reps_q == CNT_W'(1)) begin
              state_d      = DONE;
              dout_valid_d = 1'b0;
            end else begin
`ifdef SEQ_GEN_GAP_EN
              if (GAP_CYCLES == 0) begin
                ld = 1'b1;
              end else begin
                state_d      = GAP;
                gap_d        = GAP_W'(GAP_CYCLES - 1);
                dout_valid_d = 1'b0;
              end
`else
              ld = 1'b1;
`endif
            end
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      GAP: begin
`ifdef SEQ_GEN_GAP_EN
        if (gap_q == '0) begin
          state_d      = SHIFT;
          ld           = 1'b1;
          dout_valid_d = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from next-state values; idle dout is forced low.
    dout_d = dout_valid_d & msb_nxt;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  seq_piso #(
    .PAT_W(PAT_W)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_dat (ld_dat),
    .shift_en (shift_en),
    .msb_nxt  (msb_nxt),
    .last     (last_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pat_q        <= '0;
      reps_q       <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      reps_q       <= reps_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef SEQ_GEN_GAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; cycle 1 is the cycle right after the start edge.
module tb_seq_pattern_gen;
  import seq_pkg::*;

  localparam int WIN = 24;
`ifdef SEQ_GEN_GAP_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic       dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  logic v_a [0:WIN];
  logic d_a [0:WIN];

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .PAT_W(4),
    .CNT_W(8),
    .GAP_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts a burst, then watches WIN cycles: stall window lo..hi, pattern
  // change at chg_c, a stray start pulse at st_c (0 disables both).
  task automatic run_burst(input string tag, input logic [3:0] pat, input logic [7:0] cnt,
                           input int lo, input int hi, input int chg_c, input int st_c,
                           input logic [31:0] exp_stream, input int exp_bits,
                           input int exp_done, input int exp_valid);
    logic [31:0] stream;
    int nbits, ndone, done_c, nvalid, nbusy, viol, busy_at_done;
    stream = '0; nbits = 0; ndone = 0; done_c = 0;
    nvalid = 0; nbusy = 0; viol = 0; busy_at_done = 0;
    @(negedge clk);
    start = 1'b1; pattern = pat; repeat_cnt = cnt; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      if (c == chg_c) pattern = 4'b0110;
      start      = (c == st_c);
      dout_ready = !(c >= lo && c <= hi);
      v_a[c] = dout_valid;
      d_a[c] = dout;
      if (dout_valid) nvalid++;
      if (busy) nbusy++;
      if (!dout_valid && dout) viol++;
      if (done) begin
        ndone++;
        done_c = c;
        busy_at_done = int'(busy);
      end
      if (dout_valid && dout_ready) begin
        stream = {stream[30:0], dout};
        nbits++;
      end
    end
    start = 1'b0;
    dout_ready = 1'b1;
    chk({tag, "_stream"},  stream, exp_stream);
    chk({tag, "_bits"},    nbits, exp_bits);
    chk({tag, "_done_cyc"}, done_c, exp_done);
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 1);
    chk({tag, "_valid_cyc"}, nvalid, exp_valid);
    chk({tag, "_busy_cyc"},  nbusy, exp_done);
    chk({tag, "_dout0_idle"}, viol, 0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; pattern = 4'b0; repeat_cnt = 8'd0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout",  dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1010 x2, always ready
    run_burst("t1", DEFAULT_PATTERN, 8'd2, 0, 0, 0, 0, 32'hAA, 8, 9 + G, 8);
    chk("t1_v1", v_a[1], 1);
    chk("t1_d1", d_a[1], 1);
    chk("t1_d2", d_a[2], 0);
    chk("t1_v5", v_a[5], (G == 0) ? 1 : 0);

    // stall cycles 2-4: bit 0 held with valid high
    run_burst("t2", 4'b1010, 8'd2, 2, 4, 0, 0, 32'hAA, 8, 12 + G, 11);
    chk("t2_v3", v_a[3], 1);
    chk("t2_d3", d_a[3], 0);
    chk("t2_d4", d_a[4], 0);
    chk("t2_d5", d_a[5], 0);
    chk("t2_d6", d_a[6], 1);

    // three back-to-back repetitions
    run_burst("t3", 4'b1010, 8'd3, 0, 0, 0, 0, 32'hAAA, 12, 13 + 2 * G, 12);

    // pattern change at cycle 2 and start at cycle 3 are ignored
    run_burst("t4", 4'b1010, 8'd2, 0, 0, 2, 3, 32'hAA, 8, 9 + G, 8);

    // different pattern, single repetition via repeat_cnt=0
    run_burst("t6z", 4'b0011, 8'd0, 0, 0, 0, 0, 32'h3, 4, 5, 4);

    // reset at cycle 5 aborts immediately, no done afterwards
    @(negedge clk);
    start = 1'b1; pattern = 4'b1010; repeat_cnt = 8'd2; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_pre_valid", dout_valid, (G == 0) ? 1 : 0);
    reset = 1'b1;
    #1;
    chk("t5_dout",  dout, 0);
    chk("t5_valid", dout_valid, 0);
    chk("t5_busy",  busy, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy || dout_valid) ndone++;
    end
    chk("t5_quiet", ndone, 0);
    run_burst("t5b", 4'b1010, 8'd2, 0, 0, 0, 0, 32'hAA, 8, 9 + G, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
